special_reg_file_p: RTL and testbench

SPECIAL_REG_FILE_P -- requirements
Module: special_reg_file_p

---
 rtl/scc_pkg.sv | 34 +++
 rtl/sp_unit.sv | 65 ++++++
 rtl/special_reg_file_p.sv | 129 ++++++++++++
 tb/tb_special_reg_file_p.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scc_pkg.sv
// Shared encodings for the special register file: register indices,
// stack-pointer operation codes and CPSR field positions.
package scc_pkg;

    localparam logic [2:0] IDX_ZR   = 3'd0;
    localparam logic [2:0] IDX_R1   = 3'd1;
    localparam logic [2:0] IDX_R2   = 3'd2;
    localparam logic [2:0] IDX_R3   = 3'd3;
    localparam logic [2:0] IDX_SP   = 3'd4;
    localparam logic [2:0] IDX_LR   = 3'd5;
    localparam logic [2:0] IDX_PC   = 3'd6;
    localparam logic [2:0] IDX_CPSR = 3'd7;

    typedef enum logic [1:0] {
        SP_NONE = 2'b00,
        SP_PUSH = 2'b01,
        SP_POP  = 2'b10,
        SP_RSVD = 2'b11
    } sp_op_e;

    // Flag order within flag_mask / flags_in; the same order is kept in the
    // top CPSR_FLAG_W bits of the CPSR, with N as the most significant bit.
    localparam int CPSR_FLAG_W   = 4;
    localparam int FLAG_N        = 3;
    localparam int FLAG_Z        = 2;
    localparam int FLAG_C        = 1;
    localparam int FLAG_V        = 0;
    localparam int CPSR_MODE_BIT = 0;

    function automatic int cpsr_flag_lsb(input int data_w);
        return data_w - CPSR_FLAG_W;
    endfunction

endpackage

// File: rtl/sp_unit.sv
// Stack pointer register with bounded push/pop and a sticky fault flag.
// A push or pop always outranks a general write to SP in the same cycle.
module sp_unit
    import scc_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] SP_TOP     = DATA_W'(32'h0000_FFFC),
    parameter logic [DATA_W-1:0] SP_BOTTOM  = DATA_W'(32'h0000_F000),
    parameter int                WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        sp_op,
    input  logic              sp_wr_en,
    input  logic [DATA_W-1:0] sp_wr_data,
    output logic [DATA_W-1:0] sp_out,
    output logic              sp_fault
);

    localparam logic [DATA_W-1:0] STEP = DATA_W'(WORD_BYTES);

    sp_op_e            op;
    logic [DATA_W-1:0] sp_q;
    logic [DATA_W-1:0] sp_nxt;
    logic              fault_q;
    logic              fault_nxt;

    assign op = sp_op_e'(sp_op);

    always_comb begin
        sp_nxt    = sp_q;
        fault_nxt = fault_q;
        case (op)
            SP_PUSH: begin
                if (sp_q <= SP_BOTTOM) fault_nxt = 1'b1;
                else                   sp_nxt    = sp_q - STEP;
            end
            SP_POP: begin
                if (sp_q >= SP_TOP) fault_nxt = 1'b1;
                else                sp_nxt    = sp_q + STEP;
            end
            default: begin
                // Only an accepted general write re-arms the fault flag.
                if (sp_wr_en) begin
                    sp_nxt    = sp_wr_data;
                    fault_nxt = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q    <= SP_TOP;
            fault_q <= 1'b0;
        end else begin
            sp_q    <= sp_nxt;
            fault_q <= fault_nxt;
        end
    end

    assign sp_out   = sp_q;
    assign sp_fault = fault_q;

endmodule

// File: rtl/special_reg_file_p.sv
// Eight-entry special register file: zero register, three general registers,
// SP, LR, PC and CPSR, with dedicated update ports that outrank general writes.
module special_reg_file_p
    import scc_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] SP_TOP     = DATA_W'(32'h0000_FFFC),
    parameter logic [DATA_W-1:0] SP_BOTTOM  = DATA_W'(32'h0000_F000),
    parameter logic [DATA_W-1:0] PC_RESET   = '0,
    parameter int                WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              pc_wr_en,
    input  logic [DATA_W-1:0] pc_next,
    output logic [DATA_W-1:0] pc_out,
    input  logic              flag_wr_en,
    input  logic [3:0]        flag_mask,
    input  logic [3:0]        flags_in,
    output logic [DATA_W-1:0] cpsr_out,
    input  logic [1:0]        sp_op,
    output logic [DATA_W-1:0] sp_out,
    output logic              sp_fault,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_data,
    output logic [DATA_W-1:0] lr_out
);

    localparam int FLAG_LSB = cpsr_flag_lsb(DATA_W);

    logic [DATA_W-1:0]      r1_q;
    logic [DATA_W-1:0]      r2_q;
    logic [DATA_W-1:0]      r3_q;
    logic [DATA_W-1:0]      lr_q;
    logic [DATA_W-1:0]      pc_q;
    logic [CPSR_FLAG_W-1:0] flags_q;
    logic [CPSR_FLAG_W-1:0] flags_nxt;
    logic                   mode_q;

    logic wr_r1;
    logic wr_r2;
    logic wr_r3;
    logic wr_sp;
    logic wr_lr;
    logic wr_pc;
    logic wr_cpsr;

    assign wr_r1   = wr_en && (wr_addr == IDX_R1);
    assign wr_r2   = wr_en && (wr_addr == IDX_R2);
    assign wr_r3   = wr_en && (wr_addr == IDX_R3);
    assign wr_sp   = wr_en && (wr_addr == IDX_SP);
    assign wr_lr   = wr_en && (wr_addr == IDX_LR);
    assign wr_pc   = wr_en && (wr_addr == IDX_PC);
    assign wr_cpsr = wr_en && (wr_addr == IDX_CPSR);

    sp_unit #(
        .DATA_W     (DATA_W),
        .SP_TOP     (SP_TOP),
        .SP_BOTTOM  (SP_BOTTOM),
        .WORD_BYTES (WORD_BYTES)
    ) u_sp_unit (
        .clk        (clk),
        .rst        (rst),
        .sp_op      (sp_op),
        .sp_wr_en   (wr_sp),
        .sp_wr_data (wr_data),
        .sp_out     (sp_out),
        .sp_fault   (sp_fault)
    );

    // Per flag: a masked dedicated update wins, otherwise a general CPSR write.
    always_comb begin
        flags_nxt = flags_q;
        for (int i = 0; i < CPSR_FLAG_W; i++) begin
            if (flag_wr_en && flag_mask[i]) flags_nxt[i] = flags_in[i];
            else if (wr_cpsr)               flags_nxt[i] = wr_data[FLAG_LSB + i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            lr_q    <= '0;
            pc_q    <= PC_RESET;
            flags_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            if (wr_r1) r1_q <= wr_data;
            if (wr_r2) r2_q <= wr_data;
            if (wr_r3) r3_q <= wr_data;

            if (link_en)    lr_q <= link_data;
            else if (wr_lr) lr_q <= wr_data;

            if (pc_wr_en)   pc_q <= pc_next;
            else if (wr_pc) pc_q <= wr_data;

            flags_q <= flags_nxt;
            if (wr_cpsr) mode_q <= wr_data[CPSR_MODE_BIT];
        end
    end

    assign pc_out   = pc_q;
    assign lr_out   = lr_q;
    assign cpsr_out = {flags_q, {(DATA_W - CPSR_FLAG_W - 1){1'b0}}, mode_q};

    // Reads see stored state only; a same-cycle write shows up next cycle.
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            IDX_R1:   rd_data = r1_q;
            IDX_R2:   rd_data = r2_q;
            IDX_R3:   rd_data = r3_q;
            IDX_SP:   rd_data = sp_out;
            IDX_LR:   rd_data = lr_q;
            IDX_PC:   rd_data = pc_q;
            IDX_CPSR: rd_data = cpsr_out;
            default:  rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_special_reg_file_p.sv
// Self-checking bench for special_reg_file_p: reset readback, a directed
// vector table, an asynchronous reset mid-push and a random SP walk.
module tb_special_reg_file_p;

    localparam int          W      = 32;
    localparam logic [31:0] SP_TOP = 32'h0000_FFFC;
    localparam logic [31:0] SP_BOT = 32'h0000_F000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [2:0]    rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic          pc_wr_en = 1'b0;
    logic [W-1:0]  pc_next = '0;
    logic [W-1:0]  pc_out;
    logic          flag_wr_en = 1'b0;
    logic [3:0]    flag_mask = '0;
    logic [3:0]    flags_in = '0;
    logic [W-1:0]  cpsr_out;
    logic [1:0]    sp_op = '0;
    logic [W-1:0]  sp_out;
    logic          sp_fault;
    logic          link_en = 1'b0;
    logic [W-1:0]  link_data = '0;
    logic [W-1:0]  lr_out;

    special_reg_file_p dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .pc_wr_en   (pc_wr_en),
        .pc_next    (pc_next),
        .pc_out     (pc_out),
        .flag_wr_en (flag_wr_en),
        .flag_mask  (flag_mask),
        .flags_in   (flags_in),
        .cpsr_out   (cpsr_out),
        .sp_op      (sp_op),
        .sp_out     (sp_out),
        .sp_fault   (sp_fault),
        .link_en    (link_en),
        .link_data  (link_data),
        .lr_out     (lr_out)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- vectors and scoreboard ----------------
    typedef struct {
        logic         we;
        logic [2:0]   wa;
        logic [W-1:0] wd;
        logic         pce;
        logic [W-1:0] pcn;
        logic         fe;
        logic [3:0]   fm;
        logic [3:0]   fi;
        logic [1:0]   op;
        logic         le;
        logic [W-1:0] ld;
        logic [2:0]   ra;
        logic [W-1:0] e_rd;
        logic [W-1:0] e_pc;
        logic [W-1:0] e_lr;
        logic [W-1:0] e_sp;
        logic [W-1:0] e_cpsr;
        logic         e_fault;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] rd;
        logic [W-1:0] pc;
        logic [W-1:0] lr;
        logic [W-1:0] sp;
        logic [W-1:0] cpsr;
        logic         fault;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[$];

    int n_vec  = 0;
    int n_fail = 0;

    function automatic vec_t mk(
        input logic we, input logic [2:0] wa, input logic [W-1:0] wd,
        input logic pce, input logic [W-1:0] pcn,
        input logic fe, input logic [3:0] fm, input logic [3:0] fi,
        input logic [1:0] op, input logic le, input logic [W-1:0] ld,
        input logic [2:0] ra,
        input logic [W-1:0] e_rd, input logic [W-1:0] e_pc, input logic [W-1:0] e_lr,
        input logic [W-1:0] e_sp, input logic [W-1:0] e_cpsr, input logic e_fault);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.pce = pce; v.pcn = pcn;
        v.fe = fe; v.fm = fm; v.fi = fi; v.op = op; v.le = le; v.ld = ld;
        v.ra = ra; v.e_rd = e_rd; v.e_pc = e_pc; v.e_lr = e_lr;
        v.e_sp = e_sp; v.e_cpsr = e_cpsr; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        pc_wr_en = 1'b0; pc_next = '0;
        flag_wr_en = 1'b0; flag_mask = '0; flags_in = '0;
        sp_op = '0; link_en = 1'b0; link_data = '0;
    endtask

    // Drive one vector at the falling edge, queue its expectation, then
    // compare against the outputs just after the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
        pc_wr_en = v.pce; pc_next = v.pcn;
        flag_wr_en = v.fe; flag_mask = v.fm; flags_in = v.fi;
        sp_op = v.op; link_en = v.le; link_data = v.ld; rd_addr = v.ra;
        e.rd = v.e_rd; e.pc = v.e_pc; e.lr = v.e_lr;
        e.sp = v.e_sp; e.cpsr = v.e_cpsr; e.fault = v.e_fault;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({tag, ".rd"},    rd_data,  got.rd);
        check({tag, ".pc"},    pc_out,   got.pc);
        check({tag, ".lr"},    lr_out,   got.lr);
        check({tag, ".sp"},    sp_out,   got.sp);
        check({tag, ".cpsr"},  cpsr_out, got.cpsr);
        check({tag, ".fault"}, {{(W-1){1'b0}}, sp_fault}, {{(W-1){1'b0}}, got.fault});
    endtask

    // ---------------- test ----------------
    initial begin
        logic [W-1:0] m_sp;
        logic         m_fault;

        //           we wa wd            pce pcn    fe fm    fi     op    le ld     ra | rd            pc     lr     sp     cpsr          f
        tbl.push_back(mk(1, 6, 32'h80,       1, 32'h40, 0, 4'h0, 4'h0, 2'd0, 0, 32'h0,   6, 32'h40,       32'h40, 32'h0,   32'hFFFC, 32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  1, 4'hA, 4'hF, 2'd0, 0, 32'h0,   7, 32'hA000_0000, 32'h40, 32'h0,   32'hFFFC, 32'hA000_0000, 0));
        tbl.push_back(mk(1, 7, 32'hFFFF_FFFF, 0, 32'h0, 1, 4'h8, 4'h0, 2'd0, 0, 32'h0,   7, 32'h7000_0001, 32'h40, 32'h0,   32'hFFFC, 32'h7000_0001, 0));
        tbl.push_back(mk(1, 1, 32'h1111_1111, 0, 32'h0, 0, 4'h0, 4'h0, 2'd0, 0, 32'h0,   1, 32'h1111_1111, 32'h40, 32'h0,   32'hFFFC, 32'h7000_0001, 0));
        tbl.push_back(mk(1, 2, 32'h2222,     0, 32'h0,  0, 4'h0, 4'h0, 2'd0, 0, 32'h0,   1, 32'h1111_1111, 32'h40, 32'h0,   32'hFFFC, 32'h7000_0001, 0));
        tbl.push_back(mk(1, 3, 32'h3333,     0, 32'h0,  0, 4'h0, 4'h0, 2'd0, 0, 32'h0,   2, 32'h2222,     32'h40, 32'h0,   32'hFFFC, 32'h7000_0001, 0));
        tbl.push_back(mk(1, 0, 32'h55,       0, 32'h0,  0, 4'h0, 4'h0, 2'd0, 0, 32'h0,   0, 32'h0,        32'h40, 32'h0,   32'hFFFC, 32'h7000_0001, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  0, 4'h0, 4'h0, 2'd0, 0, 32'h0,   3, 32'h3333,     32'h40, 32'h0,   32'hFFFC, 32'h7000_0001, 0));
        tbl.push_back(mk(1, 5, 32'h200,      0, 32'h0,  0, 4'h0, 4'h0, 2'd0, 1, 32'h100, 5, 32'h100,      32'h40, 32'h100, 32'hFFFC, 32'h7000_0001, 0));
        tbl.push_back(mk(1, 5, 32'h300,      0, 32'h0,  0, 4'h0, 4'h0, 2'd0, 0, 32'h0,   5, 32'h300,      32'h40, 32'h300, 32'hFFFC, 32'h7000_0001, 0));
        tbl.push_back(mk(1, 4, 32'hF004,     0, 32'h0,  0, 4'h0, 4'h0, 2'd0, 0, 32'h0,   4, 32'hF004,     32'h40, 32'h300, 32'hF004, 32'h7000_0001, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  0, 4'h0, 4'h0, 2'd1, 0, 32'h0,   4, 32'hF000,     32'h40, 32'h300, 32'hF000, 32'h7000_0001, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  0, 4'h0, 4'h0, 2'd1, 0, 32'h0,   4, 32'hF000,     32'h40, 32'h300, 32'hF000, 32'h7000_0001, 1));
        tbl.push_back(mk(1, 4, 32'hF100,     0, 32'h0,  0, 4'h0, 4'h0, 2'd0, 0, 32'h0,   4, 32'hF100,     32'h40, 32'h300, 32'hF100, 32'h7000_0001, 0));
        tbl.push_back(mk(1, 4, 32'h1234,     0, 32'h0,  0, 4'h0, 4'h0, 2'd1, 0, 32'h0,   4, 32'hF0FC,     32'h40, 32'h300, 32'hF0FC, 32'h7000_0001, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  0, 4'h0, 4'h0, 2'd2, 0, 32'h0,   4, 32'hF100,     32'h40, 32'h300, 32'hF100, 32'h7000_0001, 0));
        tbl.push_back(mk(1, 4, 32'hFFFC,     0, 32'h0,  0, 4'h0, 4'h0, 2'd3, 0, 32'h0,   4, 32'hFFFC,     32'h40, 32'h300, 32'hFFFC, 32'h7000_0001, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  0, 4'h0, 4'h0, 2'd2, 0, 32'h0,   4, 32'hFFFC,     32'h40, 32'h300, 32'hFFFC, 32'h7000_0001, 1));
        tbl.push_back(mk(1, 4, 32'hFFF8,     0, 32'h0,  0, 4'h0, 4'h0, 2'd0, 0, 32'h0,   4, 32'hFFF8,     32'h40, 32'h300, 32'hFFF8, 32'h7000_0001, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  0, 4'h0, 4'h0, 2'd2, 0, 32'h0,   4, 32'hFFFC,     32'h40, 32'h300, 32'hFFFC, 32'h7000_0001, 0));
        tbl.push_back(mk(1, 6, 32'h80,       0, 32'h0,  0, 4'h0, 4'h0, 2'd0, 0, 32'h0,   6, 32'h80,       32'h80, 32'h300, 32'hFFFC, 32'h7000_0001, 0));
        tbl.push_back(mk(1, 7, 32'hF000_0000, 0, 32'h0, 1, 4'h5, 4'h0, 2'd0, 0, 32'h0,   7, 32'hA000_0000, 32'h80, 32'h300, 32'hFFFC, 32'hA000_0000, 0));

        // ---- reset state and full readback ----
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst.sp",    sp_out,   SP_TOP);
        check("rst.pc",    pc_out,   32'h0);
        check("rst.lr",    lr_out,   32'h0);
        check("rst.cpsr",  cpsr_out, 32'h0);
        check("rst.fault", {31'h0, sp_fault}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            check($sformatf("rst.rd%0d", i), rd_data, (i == 4) ? SP_TOP : 32'h0);
        end

        // ---- directed table ----
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // ---- asynchronous reset in the middle of a push with link capture ----
        @(negedge clk);
        sp_op = 2'd1; link_en = 1'b1; link_data = 32'hABC;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h99;
        rd_addr = 3'd1;
        #2 rst = 1'b1;
        #1;
        check("arst.sp_now", sp_out, SP_TOP);
        check("arst.lr_now", lr_out, 32'h0);
        check("arst.pc_now", pc_out, 32'h0);
        check("arst.r1_now", rd_data, 32'h0);
        @(posedge clk);
        #1;
        check("arst.sp_edge", sp_out, SP_TOP);
        check("arst.lr_edge", lr_out, 32'h0);
        check("arst.r1_edge", rd_data, 32'h0);
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        apply(mk(0, 0, 32'h0, 0, 32'h0, 0, 4'h0, 4'h0, 2'd1, 0, 32'h0, 4,
                 32'hFFF8, 32'h0, 32'h0, 32'hFFF8, 32'h0, 0), "post_rst_push");

        // ---- random SP walk against a behavioural stack model ----
        m_sp    = 32'hFFF8;
        m_fault = 1'b0;
        for (int n = 0; n < 80; n++) begin
            int           r;
            logic [1:0]   op;
            logic         we;
            logic [W-1:0] wd;
            r  = $urandom_range(0, 9);
            op = (r < 4) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd0 : 2'd3;
            we = (r >= 8) || ($urandom_range(0, 3) == 0);
            wd = $urandom_range(0, 1) ? SP_BOT + 32'(4 * $urandom_range(0, 3))
                                      : SP_TOP - 32'(4 * $urandom_range(0, 3));
            if (op == 2'd1) begin
                if (m_sp <= SP_BOT) m_fault = 1'b1;
                else                m_sp = m_sp - 32'd4;
            end else if (op == 2'd2) begin
                if (m_sp >= SP_TOP) m_fault = 1'b1;
                else                m_sp = m_sp + 32'd4;
            end else if (we) begin
                m_sp    = wd;
                m_fault = 1'b0;
            end
            apply(mk(we, 3'd4, wd, 0, 32'h0, 0, 4'h0, 4'h0, op, 0, 32'h0, 4,
                     m_sp, 32'h0, 32'h0, m_sp, 32'h0, m_fault), $sformatf("rnd%0d", n));
        end

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
